// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, forwarding-select codes,
// pipeline control bundle and inter-stage buffer register layouts.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned RF_ADDR_W      = 5;
    localparam int unsigned FWD_SEL_W      = 3;
    localparam int unsigned FWD_STAGES_MAX = 4;

    // fwd_sel value k (1..FWD_STAGES) selects post-EX stage k; 0 is the register file
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF = 3'd0;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALTED   = 3'd3,
        ST_ERROR    = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } pipe_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_reg_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic [RF_ADDR_W-1:0] rd;
        logic                 memread;
        logic                 regwrite;
    } idex_reg_t;

    // Full-pipeline hold: nothing advances, nothing is squashed
    function automatic pipe_ctrl_t freeze_ctrl();
        pipe_ctrl_t c;
        c             = '0;
        c.pc_stall    = 1'b1;
        c.ifid_stall  = 1'b1;
        c.pipe_freeze = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source select for one EX operand: nearest writing stage whose
// destination matches the (non-zero) source register wins.
module fwd_select
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_WIDTH = 5,
    parameter int unsigned FWD_STAGES        = 2
) (
    input  logic [REG_ADDRESS_WIDTH-1:0]            src_i,
    input  logic [FWD_STAGES*REG_ADDRESS_WIDTH-1:0] stg_rd_i,
    input  logic [FWD_STAGES-1:0]                   stg_regwrite_i,
    output logic [FWD_SEL_W-1:0]                    sel_o
);

    // Scan farthest to nearest so the nearest match overwrites the others
    always_comb begin
        sel_o = FWD_SEL_RF;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (stg_regwrite_i[i] && (src_i != '0) &&
                (stg_rd_i[i*REG_ADDRESS_WIDTH +: REG_ADDRESS_WIDTH] == src_i)) begin
                sel_o = FWD_SEL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// memory-wait freeze with timeout, and halt drain.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_WIDTH = 5,
    parameter int unsigned FWD_STAGES        = 2,
    parameter int unsigned MEM_TIMEOUT       = 15,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [REG_ADDRESS_WIDTH-1:0]            id_rs1,
    input  logic [REG_ADDRESS_WIDTH-1:0]            id_rs2,
    input  logic                                    id_use1,
    input  logic                                    id_use2,
    input  logic [REG_ADDRESS_WIDTH-1:0]            ex_rs1,
    input  logic [REG_ADDRESS_WIDTH-1:0]            ex_rs2,
    input  logic [REG_ADDRESS_WIDTH-1:0]            ex_rd,
    input  logic                                    ex_memread,
    input  logic [FWD_STAGES*REG_ADDRESS_WIDTH-1:0] stg_rd,
    input  logic [FWD_STAGES-1:0]                   stg_regwrite,
    input  logic                                    branch_taken,
    input  logic                                    halt_ex,
    input  logic                                    mem_req,
    input  logic                                    mem_ready,
    output logic                                    pc_stall,
    output logic                                    ifid_stall,
    output logic                                    ifid_flush,
    output logic                                    idex_bubble,
    output logic                                    pipe_freeze,
    output logic [2:0]                              fwd_sel_a,
    output logic [2:0]                              fwd_sel_b,
    output logic                                    halted,
    output logic                                    mem_err,
    output logic [2:0]                              state,
    output logic [CNT_WIDTH-1:0]                    stall_cnt
);

    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRAIN_W = 3;

    state_e               state_q,     state_d;
    logic [WAIT_W-1:0]    wait_cnt_q,  wait_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    pipe_ctrl_t           ctrl_c;
    logic                 mem_stall_c;
    logic                 load_use_c;

    fwd_select #(
        .REG_ADDRESS_WIDTH(REG_ADDRESS_WIDTH),
        .FWD_STAGES       (FWD_STAGES)
    ) u_fwd_a (
        .src_i         (ex_rs1),
        .stg_rd_i      (stg_rd),
        .stg_regwrite_i(stg_regwrite),
        .sel_o         (fwd_sel_a)
    );

    fwd_select #(
        .REG_ADDRESS_WIDTH(REG_ADDRESS_WIDTH),
        .FWD_STAGES       (FWD_STAGES)
    ) u_fwd_b (
        .src_i         (ex_rs2),
        .stg_rd_i      (stg_rd),
        .stg_regwrite_i(stg_regwrite),
        .sel_o         (fwd_sel_b)
    );

    assign mem_stall_c = mem_req && !mem_ready;
    assign load_use_c  = ex_memread && (ex_rd != '0) &&
                         ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

    // Next state, counters and control outputs; priority freeze > branch > halt > load-use
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;
        ctrl_c      = '0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall_c) begin
                    ctrl_c     = freeze_ctrl();
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (branch_taken) begin
                    ctrl_c.ifid_flush  = 1'b1;
                    ctrl_c.idex_bubble = 1'b1;
                end else if (halt_ex) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_W'(FWD_STAGES);
                end else if (load_use_c) begin
                    ctrl_c.pc_stall    = 1'b1;
                    ctrl_c.ifid_stall  = 1'b1;
                    ctrl_c.idex_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctrl_c     = freeze_ctrl();
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d    = ST_ERROR;
                        wait_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_stall_c) begin
                    ctrl_c = freeze_ctrl();
                end else begin
                    ctrl_c.pc_stall    = 1'b1;
                    ctrl_c.ifid_flush  = 1'b1;
                    ctrl_c.idex_bubble = 1'b1;
                    if (drain_cnt_q <= DRAIN_W'(1)) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    end
                end
            end
            ST_HALTED, ST_ERROR: begin
                ctrl_c = freeze_ctrl();
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Only stalls seen while the pipe is live are counted
        if (ctrl_c.pc_stall && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
            (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_stall    = ctrl_c.pc_stall;
    assign ifid_stall  = ctrl_c.ifid_stall;
    assign ifid_flush  = ctrl_c.ifid_flush;
    assign idex_bubble = ctrl_c.idex_bubble;
    assign pipe_freeze = ctrl_c.pipe_freeze;
    assign halted      = (state_q == ST_HALTED);
    assign mem_err     = (state_q == ST_ERROR);
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL take parameter REG_ADDRESS_WIDTH, default 5, register-specifier width.
REQ-002 SHALL take parameter FWD_STAGES, default 2 (legal 1..4), number of post-EX stages tracked as forwarding sources (index 1 = nearest to EX).
REQ-003 SHALL take parameter MEM_TIMEOUT, default 15, maximum MEM_WAIT cycles before error.
REQ-004 SHALL take parameter CNT_WIDTH, default 16, width of the stall counter.
REQ-005 Ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-006 Ports: id_rs1, id_rs2  in  REG_ADDRESS_WIDTH each  ID-stage sources; id_use1, id_use2  in  1 each  source actually read.
REQ-007 Ports: ex_rs1, ex_rs2  in  REG_ADDRESS_WIDTH each  EX-stage sources; ex_rd  in  REG_ADDRESS_WIDTH  EX destination; ex_memread  in  1  EX holds a load.
REQ-008 Ports: stg_rd  in  FWD_STAGES*REG_ADDRESS_WIDTH  packed destinations; stg_regwrite  in  FWD_STAGES  per-stage write enable.
REQ-009 Ports: branch_taken, halt_ex  in  1 each  from EX; mem_req, mem_ready  in  1 each  data-memory handshake.
REQ-010 Ports: pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze  out  1 each  pipeline controls.
REQ-011 Ports: fwd_sel_a, fwd_sel_b  out  3 each  0 = register file, k = stage k.
REQ-012 Ports: halted, mem_err  out  1 each  status; state  out  3  FSM state; stall_cnt  out  CNT_WIDTH  stall-cycle count.

Function
REQ-013 FSM states: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERROR=4.
REQ-014 Forwarding, combinational, in every state: fwd_sel_a = smallest k with stg_regwrite[k] and stg_rd[k]==ex_rs1 and ex_rs1!=0, else 0; fwd_sel_b likewise with ex_rs2.
REQ-015 Load-use in RUN: ex_memread, ex_rd!=0, and (id_use1 and id_rs1==ex_rd, or id_use2 and id_rs2==ex_rd) -> pc_stall=ifid_stall=idex_bubble=1 for that cycle only; no state change.
REQ-016 Branch in RUN: branch_taken -> ifid_flush=idex_bubble=1 same cycle; pc_stall=0 so the target loads; suppresses the load-use stall that cycle.
REQ-017 RUN, mem_req and not mem_ready -> MEM_WAIT next cycle; pipe_freeze=pc_stall=ifid_stall=1 combinationally from that cycle, and branch/load-use outputs are masked.
REQ-018 MEM_WAIT: wait counter increments each cycle; mem_ready -> RUN next cycle, freeze released in the cycle mem_ready is seen; counter reaching MEM_TIMEOUT without mem_ready -> ERROR.
REQ-019 RUN, halt_ex and not branch_taken and no freeze -> DRAIN; drain counter loads FWD_STAGES; halt_ex in the same cycle as branch_taken is ignored (squashed).
REQ-020 DRAIN: pc_stall=ifid_flush=idex_bubble=1 each cycle; pipe_freeze=0 so older instructions retire; counter decrements; at 0 -> HALTED; mem_req and not mem_ready in DRAIN freezes without decrementing.
REQ-021 HALTED: halted=1, pc_stall=ifid_stall=pipe_freeze=1; terminal until reset.
REQ-022 ERROR: mem_err=1, pc_stall=ifid_stall=pipe_freeze=1; terminal until reset.
REQ-023 Priority when events coincide: ERROR/HALTED > memory freeze > branch flush > halt entry > load-use.
REQ-024 stall_cnt increments in every cycle with pc_stall=1 and state in {RUN, MEM_WAIT}; saturates at all-ones.

Reset
REQ-025 rst low asynchronously forces state=RUN, all counters 0, halted=0, mem_err=0; control outputs follow from RUN with deasserted inputs, all 0.
REQ-026 Reset asserted mid-MEM_WAIT or mid-DRAIN SHALL abort the operation; the first post-reset cycle is RUN.

Structure
REQ-027 State encoding enum and the fwd_sel encoding constants SHALL live in the shared pipeline package alongside the buffer-register typedefs.
REQ-028 One sub-module, fwd_select, SHALL implement REQ-014 for one operand and be instantiated twice.

Verification
REQ-029 ex_memread=1, ex_rd=5, id_rs1=5, id_use1=1 -> pc_stall=ifid_stall=idex_bubble=1 one cycle; stall_cnt 0->1.
REQ-030 ex_rs1=7, stg_rd[1]=7 and stg_rd[2]=7 both writing -> fwd_sel_a=1; ex_rs2=0 with stg_rd[1]=0 writing -> fwd_sel_b=0.
REQ-031 mem_req=1, mem_ready low 3 cycles then high -> state 0,1,1,1,0; pipe_freeze high exactly 3 cycles.
REQ-032 mem_ready never asserted, MEM_TIMEOUT=15 -> ERROR after 15 MEM_WAIT cycles, mem_err=1 held until rst low.
REQ-033 halt_ex=1 with FWD_STAGES=2 -> DRAIN 2 cycles, then halted=1; halt_ex with branch_taken same cycle -> stays RUN, flush only.
REQ-034 rst low during DRAIN -> state=0, halted=0, counters 0 immediately, without a clock edge.
